cube: RTL and testbench

- Sequential integer cube unit: result = x_i^3, computed with an internal shift-add multiplier over two passes (x*x, then (x*x)*x).
- Inverse direction of the team's integer cube-root block, with the same start/busy handshake so the two chain directly.
- Primary uses: round-trip checking of cube-root results (cube(cbrt(x)) <= x) and generating cube-root operands on-chip.
- The ovf flag marks cubes that exceed the 16-bit cube-root input range.

---
 rtl/cube.sv | 151 +++++++++++++++
 tb/tb_cube.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/cube.sv
`default_nettype none
// ============================================================================
// Module   : cube
// Purpose  : Sequential unsigned integer cube, result = x_i^3. A shift-add
//            multiplier runs two passes: SQ forms x*x over WIDTH cycles, and
//            CB forms (x*x)*x over another WIDTH cycles. The start/busy
//            handshake matches the integer cube-root block, so the two can be
//            chained directly.
// Ports    : clk    - rising-edge clock
//            rst    - asynchronous, active-low reset
//            x_i    - unsigned operand, latched on the accepting edge only
//            start  - request, honoured only when idle
//            result - registered cube, holds until the next completion
//            busy   - high while a computation is in progress
//            ovf    - registered, result exceeds the 16-bit cube-root range
// Revision : 1.0 - initial release
// ============================================================================
module cube #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   x_i,
  input  logic               start,
  output logic [3*WIDTH-1:0] result,
  output logic               busy,
  output logic               ovf
);

  localparam int c_cw = $clog2(WIDTH);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_sq   = 2'd1;
  localparam logic [1:0] c_st_cb   = 2'd2;

  localparam logic [c_cw-1:0] c_cnt_last = c_cw'(WIDTH - 1);

  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  logic [WIDTH-1:0]     r_x;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_sq;
  logic [3*WIDTH-1:0]   r_acc2;
  logic [c_cw-1:0]      r_cnt;
  logic [3*WIDTH-1:0]   r_result;
  logic                 r_ovf;

  logic                 w_last;
  logic                 w_bit;
  logic [2*WIDTH-1:0]   w_sq_step;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [3*WIDTH-1:0]   w_cb_step;
  logic [3*WIDTH-1:0]   w_acc2_next;
  logic                 w_ovf_next;

  // Both passes walk the bits of the latched operand with the same counter;
  // each pass adds its multiplicand, shifted by the bit position, when the
  // current operand bit is set.
  assign w_last      = (r_cnt == c_cnt_last);
  assign w_bit       = r_x[r_cnt];
  assign w_sq_step   = w_bit ? ({{WIDTH{1'b0}}, r_x} << r_cnt) : '0;
  assign w_acc_next  = r_acc + w_sq_step;
  assign w_cb_step   = w_bit ? ({{WIDTH{1'b0}}, r_sq} << r_cnt) : '0;
  assign w_acc2_next = r_acc2 + w_cb_step;

  // Overflow only exists when the result is wider than the 16-bit range.
  generate
    if (3 * WIDTH > 16) begin : g_ovf
      assign w_ovf_next = |w_acc2_next[3*WIDTH-1:16];
    end else begin : g_no_ovf
      assign w_ovf_next = 1'b0;
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: if (start)  w_state_next = c_st_sq;
      c_st_sq:   if (w_last) w_state_next = c_st_cb;
      c_st_cb:   if (w_last) w_state_next = c_st_idle;
      default:               w_state_next = c_st_idle;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (r_state != c_st_idle);
  end

  // Datapath. result/ovf are written only on the final CB edge, so the
  // previous answer stays readable for the whole busy window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x      <= '0;
      r_acc    <= '0;
      r_sq     <= '0;
      r_acc2   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_x   <= x_i;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        c_st_sq: begin
          r_acc <= w_acc_next;
          if (w_last) begin
            r_sq   <= w_acc_next;
            r_acc2 <= '0;
            r_cnt  <= '0;
          end else begin
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        c_st_cb: begin
          r_acc2 <= w_acc2_next;
          if (w_last) begin
            r_result <= w_acc2_next;
            r_ovf    <= w_ovf_next;
            r_cnt    <= '0;
          end else begin
            r_cnt    <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign result = r_result;
  assign ovf    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cube.sv
`default_nettype none
// ============================================================================
// Module   : tb_cube
// Purpose  : Self-checking bench for cube (WIDTH=8). Expected cubes are pushed
//            to a scoreboard queue when a request is driven and popped when
//            busy falls. Covers reset, boundary operands, the cube-root range
//            edge, handshake robustness, asynchronous mid-operation reset and
//            a cube-root round-trip sweep over 0..65535.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cube;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst;
  logic [WIDTH-1:0]   x_i;
  logic               start;
  logic [3*WIDTH-1:0] result;
  logic               busy;
  logic               ovf;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries are {ovf, result}.
  logic [3*WIDTH:0] sb_q[$];

  logic [3*WIDTH-1:0] dut_cubes [0:41];

  cube #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .x_i    (x_i),
    .start  (start),
    .result (result),
    .busy   (busy),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the DUT idle. Drives a request, counts the
  // busy cycles, checks that result holds through the busy window, then pops
  // the scoreboard and compares. With disturb set, extra start pulses with a
  // different operand land at busy cycles 4 and 16 and x_i churns every cycle.
  task automatic do_op(input logic [WIDTH-1:0] x, input bit disturb,
                       input string tag, output logic [3*WIDTH-1:0] got);
    logic [3*WIDTH-1:0] prev;
    logic [3*WIDTH:0]   exp;
    logic [31:0]        cube_val;
    int                 n;
    bit                 held;
    cube_val = 32'(x) * 32'(x) * 32'(x);
    sb_q.push_back({(cube_val > 32'd65535), cube_val[3*WIDTH-1:0]});
    prev  = result;
    x_i   = x;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n     = 0;
    held  = 1'b1;
    while (busy && n < 100) begin
      n++;
      if (result !== prev) held = 1'b0;
      if (disturb) begin
        start = (n == 4 || n == 16);
        x_i   = (n == 4 || n == 16) ? 8'd9 : 8'($urandom);
      end
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 32'(n), 32'd16);
    check({tag, " result_held"}, 32'(held), 32'd1);
    exp = sb_q.pop_front();
    check({tag, " result"}, 32'(result), 32'(exp[3*WIDTH-1:0]));
    check({tag, " ovf"}, 32'(ovf), 32'(exp[3*WIDTH]));
    got = result;
  endtask

  initial begin
    logic [3*WIDTH-1:0] r;
    int n;
    int c;
    int bad;

    rst   = 1'b0;
    start = 1'b0;
    x_i   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset result", 32'(result), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    check("reset busy", 32'(busy), 32'd0);

    do_op(8'd3,   1'b0, "x3",   r);
    do_op(8'd0,   1'b0, "x0",   r);
    do_op(8'd1,   1'b0, "x1",   r);
    do_op(8'd255, 1'b0, "x255", r);
    do_op(8'd40,  1'b0, "x40",  r);
    do_op(8'd41,  1'b0, "x41",  r);

    // Handshake: the stray start at busy cycle 16 is still high when the
    // DUT returns to idle, so the following request lands on the first
    // idle edge.
    do_op(8'd5, 1'b1, "hs5", r);
    do_op(8'd9, 1'b0, "hs9", r);

    // Asynchronous reset in the middle of an operation.
    x_i   = 8'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 10) begin
      n++;
      if (n < 10) @(negedge clk);
    end
    check("midrst busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst result", 32'(result), 32'd0);
    check("midrst ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_op(8'd2, 1'b0, "after_rst", r);

    // Cube-root round trip: cube every candidate root with the DUT, then
    // confirm each x in 0..65535 sits between cube(c) and cube(c+1).
    for (int k = 0; k <= 41; k++) begin
      do_op(8'(k), 1'b0, "rt", r);
      dut_cubes[k] = r;
    end
    c   = 0;
    bad = 0;
    for (int xv = 0; xv <= 65535; xv++) begin
      while ((c + 1) * (c + 1) * (c + 1) <= xv) c++;
      if (!(32'(dut_cubes[c]) <= 32'(xv) && 32'(dut_cubes[c+1]) > 32'(xv))) bad++;
    end
    check("roundtrip violations", 32'(bad), 32'd0);
    check("scoreboard empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
